// File: rtl/audio_pll_seq_pkg.sv
// Shared definitions for the audio PLL lock sequencer.
//   seq_state_t  : sequencer states
//   LOSS_CNT_W   : width of the lock-loss event counter
//   cnt_width()  : width of the shared down-counter, sized for the largest load value
package audio_pll_seq_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PLL_RESET,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAULT
  } seq_state_t;

  // The counter only ever holds (N-1) down to 0, so clog2 of the largest N is enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/audio_pll_seq_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the refclk domain.
// Ports:
//   clk  in  sampling clock
//   rst  in  synchronous active-high reset, clears both stages to 0
//   din  in  asynchronous input
//   dout out synchronized output, two cycles of latency
module audio_pll_seq_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/audio_pll_lock_sequencer.sv
// Audio PLL lock sequencer: pulses the PLL reset, waits for lock with timeout and retry,
// qualifies lock stability, then releases the audio-domain reset. Loss of lock while
// running re-sequences the PLL and is reported through sticky status.
// Ports:
//   refclk        in   reference clock, sole clock of the block
//   rst           in   synchronous active-high reset
//   enable        in   level request to run; low forces IDLE
//   status_clr    in   pulse clearing lock_lost and loss_count
//   pll_locked_i  in   PLL lock flag, asynchronous
//   pll_rst_o     out  PLL reset, active high
//   audio_rst_o   out  audio core reset, active high
//   ready         out  high only in RUN
//   fault         out  high only in FAULT
//   lock_lost     out  sticky lock-loss-in-RUN flag
//   retry_count   out  failed lock attempts since last RUN entry
//   loss_count    out  saturating count of lock-loss events
// Build option: define AUDIO_PLL_SEQ_LOSS_CNT_EN to implement loss_count; otherwise it reads 0.
module audio_pll_lock_sequencer
  import audio_pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                              refclk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              status_clr,
  input  logic                              pll_locked_i,
  output logic                              pll_rst_o,
  output logic                              audio_rst_o,
  output logic                              ready,
  output logic                              fault,
  output logic                              lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]  retry_count,
  output logic [LOSS_CNT_W-1:0]             loss_count
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  seq_state_t      state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   retry_n, retry_inc;
  logic            lock_s;
  logic            loss_evt;
  logic            pll_rst_n, audio_rst_n, ready_n, fault_n, lock_lost_n;

  audio_pll_seq_sync u_sync (
    .clk  (refclk),
    .rst  (rst),
    .din  (pll_locked_i),
    .dout (lock_s)
  );

  assign retry_inc = retry_count + RW'(1);

  // One down-counter serves every timed state: it is loaded with (N-1) on entry and the
  // state acts when it reads zero, so each timed state lasts exactly N cycles.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    retry_n  = retry_count;
    loss_evt = 1'b0;

    case (state)
      IDLE: begin
        state_n = PLL_RESET;
        cnt_n   = RST_LOAD;
        retry_n = '0;
      end
      PLL_RESET: begin
        if (cnt == '0) begin
          state_n = WAIT_LOCK;
          cnt_n   = TO_LOAD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = SETTLE;
          cnt_n   = SETTLE_LOAD;
        end else if (cnt == '0) begin
          retry_n = retry_inc;
          if (retry_inc == RETRY_MAX) begin
            state_n = FAULT;
          end else begin
            state_n = PLL_RESET;
            cnt_n   = RST_LOAD;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      SETTLE: begin
        // A dropout here restarts the lock wait without counting as a failed attempt.
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = TO_LOAD;
        end else if (cnt == '0) begin
          state_n = RUN;
          retry_n = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_n  = PLL_RESET;
          cnt_n    = RST_LOAD;
          loss_evt = 1'b1;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Dropping enable wins over everything, including a coincident lock loss.
    if (!enable) begin
      state_n  = IDLE;
      cnt_n    = '0;
      retry_n  = retry_count;
      loss_evt = 1'b0;
    end

    // Outputs are decoded from the next state so they register on the same edge as it.
    pll_rst_n   = (state_n == IDLE) || (state_n == PLL_RESET) || (state_n == FAULT);
    audio_rst_n = (state_n != RUN);
    ready_n     = (state_n == RUN);
    fault_n     = (state_n == FAULT);

    lock_lost_n = lock_lost;
    if (loss_evt) begin
      lock_lost_n = 1'b1;
    end else if (status_clr) begin
      lock_lost_n = 1'b0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst_o   <= 1'b1;
      audio_rst_o <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry_count <= retry_n;
      pll_rst_o   <= pll_rst_n;
      audio_rst_o <= audio_rst_n;
      ready       <= ready_n;
      fault       <= fault_n;
      lock_lost   <= lock_lost_n;
    end
  end

`ifdef AUDIO_PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  // A loss event takes priority over a coincident clear so no event is dropped.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_evt) begin
      if (loss_q != {LOSS_CNT_W{1'b1}}) begin
        loss_q <= loss_q + LOSS_CNT_W'(1);
      end
    end else if (status_clr) begin
      loss_q <= '0;
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_audio_pll_lock_sequencer.sv
// Scoreboard bench for audio_pll_lock_sequencer with short timing parameters.
// The stimulus process pushes the expected output tuple for specific cycles; a monitor
// on the falling edge pops and compares at those cycles and flags any output change
// that no expectation accounts for.
module tb_audio_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int SETTLE_CYCLES = 16;
  localparam int MAX_RETRIES   = 2;

`ifdef AUDIO_PLL_SEQ_LOSS_CNT_EN
  localparam int LC1 = 1;
`else
  localparam int LC1 = 0;
`endif

  logic refclk = 1'b0;
  logic rst;
  logic enable;
  logic status_clr;
  logic pll_locked_i;
  logic pll_rst_o;
  logic audio_rst_o;
  logic ready;
  logic fault;
  logic lock_lost;
  logic [$clog2(MAX_RETRIES+1)-1:0] retry_count;
  logic [7:0] loss_count;

  typedef struct {
    int          cyc;
    int          tag;
    logic [14:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic [14:0] prev;
  bit          have_prev = 1'b0;

  audio_pll_lock_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .enable       (enable),
    .status_clr   (status_clr),
    .pll_locked_i (pll_locked_i),
    .pll_rst_o    (pll_rst_o),
    .audio_rst_o  (audio_rst_o),
    .ready        (ready),
    .fault        (fault),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count),
    .loss_count   (loss_count)
  );

  always #10 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  // Tuple order: pll_rst, audio_rst, ready, fault, lock_lost, retry_count[1:0], loss_count[7:0]
  function automatic logic [14:0] tup(input bit p, input bit a, input bit r, input bit f,
                                      input bit l, input int rc, input int lc);
    return {p, a, r, f, l, 2'(rc), 8'(lc)};
  endfunction

  task automatic expectAt(input int c, input int tag, input logic [14:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input int at, input bit r, input bit en, input bit lk, input bit clr);
    repeat (at - cyc) @(negedge refclk);
    rst          = r;
    enable       = en;
    pll_locked_i = lk;
    status_clr   = clr;
  endtask

  task automatic checkOutput();
    logic [14:0] obs;
    exp_t        e;
    obs = {pll_rst_o, audio_rst_o, ready, fault, lock_lost, retry_count, loss_count};
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL T%0d cyc=%0d expectation skipped, now cyc=%0d want=%b", e.tag, e.cyc, cyc, e.val);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      n_compared++;
      if (obs !== e.val) begin
        n_mismatched++;
        $display("[TB] FAIL T%0d cyc=%0d got=%b want=%b (pll_rst,audio_rst,ready,fault,lock_lost,retry[2],loss[8])",
                 e.tag, cyc, obs, e.val);
      end
    end else if (have_prev && obs !== prev) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, obs, prev);
    end
    prev      = obs;
    have_prev = 1'b1;
  endtask

  always @(negedge refclk) begin
    if (cyc > 0) checkOutput();
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    rst          = 1'b1;
    enable       = 1'b0;
    status_clr   = 1'b0;
    pll_locked_i = 1'b0;

    // Reset state, and staying there with enable low
    expectAt(1, 0, tup(1,1,0,0,0,0,0));
    expectAt(4, 0, tup(1,1,0,0,0,0,0));
    applyStimulus(3, 0, 0, 0, 0);

    // T1 nominal: pll_rst high 4 cycles, lock 10 cycles later, RUN 18 edges after lock sampled
    expectAt(9,  1, tup(1,1,0,0,0,0,0));
    expectAt(10, 1, tup(0,1,0,0,0,0,0));
    applyStimulus(5, 0, 1, 0, 0);
    expectAt(38, 1, tup(0,1,0,0,0,0,0));
    expectAt(39, 1, tup(0,0,1,0,0,0,0));
    applyStimulus(20, 0, 1, 1, 0);

    // T2 settle glitch: one-cycle dropout restarts the settle window, no retry
    expectAt(43, 2, tup(1,1,0,0,0,0,0));
    applyStimulus(42, 0, 0, 0, 0);
    expectAt(55, 2, tup(0,1,0,0,0,0,0));
    applyStimulus(50, 0, 1, 0, 0);
    applyStimulus(60, 0, 1, 1, 0);
    expectAt(79, 2, tup(0,1,0,0,0,0,0));
    expectAt(89, 2, tup(0,1,0,0,0,0,0));
    expectAt(90, 2, tup(0,0,1,0,0,0,0));
    applyStimulus(70, 0, 1, 0, 0);
    applyStimulus(71, 0, 1, 1, 0);

    // T3 timeouts: two 100-cycle waits, then FAULT until enable drops
    expectAt(93, 3, tup(1,1,0,0,0,0,0));
    applyStimulus(92, 0, 0, 0, 0);
    expectAt(100, 3, tup(0,1,0,0,0,0,0));
    expectAt(199, 3, tup(0,1,0,0,0,0,0));
    expectAt(200, 3, tup(1,1,0,0,0,1,0));
    expectAt(204, 3, tup(0,1,0,0,0,1,0));
    expectAt(303, 3, tup(0,1,0,0,0,1,0));
    expectAt(304, 3, tup(1,1,0,1,0,2,0));
    expectAt(309, 3, tup(1,1,0,1,0,2,0));
    expectAt(311, 3, tup(1,1,0,0,0,2,0));
    applyStimulus(95, 0, 1, 0, 0);
    applyStimulus(310, 0, 0, 0, 0);

    // T4 loss in RUN, relock, clear, then clear coincident with a loss
    expectAt(316, 4, tup(1,1,0,0,0,0,0));
    expectAt(320, 4, tup(0,1,0,0,0,0,0));
    expectAt(337, 4, tup(0,0,1,0,0,0,0));
    applyStimulus(315, 0, 1, 1, 0);
    expectAt(347, 4, tup(0,0,1,0,0,0,0));
    expectAt(348, 4, tup(1,1,0,0,1,0,LC1));
    expectAt(352, 4, tup(0,1,0,0,1,0,LC1));
    expectAt(369, 4, tup(0,0,1,0,1,0,LC1));
    applyStimulus(345, 0, 1, 0, 0);
    applyStimulus(350, 0, 1, 1, 0);
    expectAt(376, 4, tup(0,0,1,0,0,0,0));
    applyStimulus(375, 0, 1, 1, 1);
    applyStimulus(376, 0, 1, 1, 0);
    expectAt(383, 4, tup(1,1,0,0,1,0,LC1));
    applyStimulus(380, 0, 1, 0, 0);
    applyStimulus(382, 0, 1, 0, 1);
    applyStimulus(383, 0, 1, 0, 0);

    // T5 aborts: enable low in PLL_RESET and SETTLE, rst pulse in RUN
    expectAt(386, 5, tup(1,1,0,0,1,0,LC1));
    applyStimulus(385, 0, 0, 0, 0);
    expectAt(395, 5, tup(0,1,0,0,1,0,LC1));
    applyStimulus(390, 0, 1, 1, 0);
    expectAt(401, 5, tup(1,1,0,0,1,0,LC1));
    expectAt(412, 5, tup(1,1,0,0,1,0,LC1));
    applyStimulus(400, 0, 0, 1, 0);
    expectAt(420, 5, tup(0,1,0,0,1,0,LC1));
    expectAt(437, 5, tup(0,0,1,0,1,0,LC1));
    applyStimulus(415, 0, 1, 1, 0);
    expectAt(446, 5, tup(1,1,0,0,0,0,0));
    expectAt(447, 5, tup(1,1,0,0,0,0,0));
    expectAt(451, 5, tup(0,1,0,0,0,0,0));
    applyStimulus(445, 1, 1, 1, 0);
    applyStimulus(446, 0, 1, 1, 0);
    expectAt(456, 5, tup(1,1,0,0,0,0,0));
    applyStimulus(455, 0, 0, 1, 0);

    applyStimulus(460, 0, 0, 0, 0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL T%0d cyc=%0d expectation never reached want=%b", e.tag, e.cyc, e.val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
